// File: rtl/led_frame_sink_if.sv
// Frame-write stream from the brightness pattern generator into the LED sink.
interface led_frame_sink_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          sdbpflag;
  logic [AW-1:0] wtaddr;
  logic [DW-1:0] wtdina;

  modport master (output sdbpflag, output wtaddr, output wtdina);
  modport slave  (input sdbpflag, input wtaddr, input wtdina);
endinterface

// File: rtl/led_frame_sink.sv
// LED frame sink: captures per-LED words into a ping-pong buffer and, on each
// sdbpflag rising edge, swaps banks and shifts the finished frame out as
// SCLK/SDO/LAT to the MiniLED driver.
module led_frame_sink #(
  parameter int NUM_LED   = 360,
  parameter int DW        = 16,
  parameter int AW        = 10,
  parameter int LATCH_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  led_frame_sink_if.slave        stream,
  output logic                   led_sclk,
  output logic                   led_sdo,
  output logic                   led_lat,
  output logic                   busy,
  output logic                   frame_drop,
  output logic [15:0]            frame_cnt
);

  localparam int MEM_DEPTH = 2 * NUM_LED;
  localparam int MAW       = $clog2(MEM_DEPTH);
  localparam int WW        = $clog2(NUM_LED);
  localparam int BW        = $clog2(DW);
  localparam int LCW       = $clog2(LATCH_LEN) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_d, addr_d2;
  logic            sdbp_d;
  logic            wr_bank;          // read bank is always the other one
  logic [WW-1:0]   widx;
  logic [BW-1:0]   bit_idx;
  logic            phase;
  logic [LCW-1:0]  lat_cnt;
  logic [DW-1:0]   rd_data;
  logic [DW-1:0]   mem [MEM_DEPTH];

  logic            sdbp_rise, wr_en, last_bit, last_word, lat_done;
  logic [MAW-1:0]  wr_off, wr_addr, rd_addr;
  logic            sclk_next, sdo_next, lat_next;

  assign sdbp_rise = stream.sdbpflag & ~sdbp_d;
  // addr_d lines up with wtdina, which arrives one clk after its address
  assign wr_en     = (addr_d != '0) && (addr_d <= AW'(NUM_LED)) && (addr_d != addr_d2);
  assign wr_off    = MAW'(addr_d - AW'(1));
  // bank 0 occupies the lower NUM_LED entries, bank 1 the upper ones
  assign wr_addr   = wr_bank ? MAW'(NUM_LED) + wr_off : wr_off;
  assign rd_addr   = wr_bank ? MAW'(widx) : MAW'(NUM_LED) + MAW'(widx);
  assign last_bit  = phase && (bit_idx == '0);
  assign last_word = (widx == WW'(NUM_LED - 1));
  assign lat_done  = (lat_cnt == LCW'(LATCH_LEN - 1));

  // Frame buffer: write port from the stream, registered read port for the shifter
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= stream.wtdina;
    if (state_reg == LOAD) rd_data <= mem[rd_addr];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sdbp_rise) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = last_word ? LATCH : LOAD;
      LATCH:   if (lat_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM pin values, registered below so SDO follows the RAM read by one clk
  always_comb begin
    sclk_next = 1'b0;
    sdo_next  = 1'b0;
    lat_next  = 1'b0;
    case (state_reg)
      SHIFT:   begin
        sdo_next  = rd_data[bit_idx];
        sclk_next = phase;
      end
      LATCH:   lat_next = 1'b1;
      default: ;
    endcase
  end

  // Pin output registers and dropped-trigger pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_sclk   <= 1'b0;
      led_sdo    <= 1'b0;
      led_lat    <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      led_sclk   <= sclk_next;
      led_sdo    <= sdo_next;
      led_lat    <= lat_next;
      frame_drop <= sdbp_rise && (state_reg != IDLE);
    end
  end

  // Capture delays, bank swap, word/bit/latch counters, busy and frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_d    <= '0;
      addr_d2   <= '0;
      sdbp_d    <= 1'b0;
      wr_bank   <= 1'b0;
      widx      <= '0;
      bit_idx   <= '0;
      phase     <= 1'b0;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      addr_d  <= stream.wtaddr;
      addr_d2 <= addr_d;
      sdbp_d  <= stream.sdbpflag;
      case (state_reg)
        IDLE: if (sdbp_rise) begin
          wr_bank <= ~wr_bank;
          busy    <= 1'b1;
          widx    <= '0;
        end
        LOAD: begin
          phase   <= 1'b0;
          bit_idx <= BW'(DW - 1);
        end
        SHIFT: begin
          phase <= ~phase;
          if (phase) begin
            if (bit_idx == '0) begin
              if (!last_word) widx <= widx + WW'(1);
              lat_cnt <= '0;
            end else begin
              bit_idx <= bit_idx - BW'(1);
            end
          end
        end
        LATCH: begin
          lat_cnt <= lat_cnt + LCW'(1);
          if (lat_done) begin
            busy      <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_sink.sv
// Self-checking bench for led_frame_sink: decodes the SCLK/SDO stream and
// compares each word against a queue of expected words pushed at trigger time.
`timescale 1ns/1ps
module tb_led_frame_sink;

  localparam int NUM_LED   = 360;
  localparam int DW        = 16;
  localparam int AW        = 10;
  localparam int LATCH_LEN = 4;
  localparam int FRAME_CLK = NUM_LED * 33 + LATCH_LEN;   // 11884

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        led_sclk, led_sdo, led_lat, busy, frame_drop;
  logic [15:0] frame_cnt;

  led_frame_sink_if #(.AW(AW), .DW(DW)) wr_if ();

  led_frame_sink #(
    .NUM_LED(NUM_LED), .DW(DW), .AW(AW), .LATCH_LEN(LATCH_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stream(wr_if),
    .led_sclk(led_sclk), .led_sdo(led_sdo), .led_lat(led_lat),
    .busy(busy), .frame_drop(frame_drop), .frame_cnt(frame_cnt)
  );

  always #20 clk = ~clk;   // 25 MHz

  int checks = 0;
  int errors = 0;

  // scoreboard and monitor statistics
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [2][NUM_LED];
  int            wr_sel = 0;
  int            sclk_rises = 0, busy_cycles = 0, lat_cycles = 0;
  int            drop_cycles = 0, words_seen = 0;
  logic [DW-1:0] pend_d = '0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            led;    // LED whose word must change, -1 when the write is ignored
  } filt_vec_t;
  filt_vec_t filt_tbl [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: decode words on SCLK rising edges and count status cycles
  initial begin
    logic          prev_sclk;
    logic [DW-1:0] shreg;
    logic [DW-1:0] exp_w;
    int            nbits;
    prev_sclk = 1'b0;
    shreg     = '0;
    nbits     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sclk = 1'b0;
        nbits     = 0;
      end else begin
        if (busy)       busy_cycles++;
        if (led_lat)    lat_cycles++;
        if (frame_drop) drop_cycles++;
        if (led_sclk && !prev_sclk) begin
          sclk_rises++;
          shreg = {shreg[DW-2:0], led_sdo};
          nbits++;
          if (nbits == DW) begin
            nbits = 0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL stray_word: got 0x%04h, expected no word", shreg);
            end else begin
              exp_w = exp_q.pop_front();
              chk($sformatf("word[%0d]", words_seen), shreg, exp_w);
              $display("word %0d: 0x%04h", words_seen, shreg);
            end
            words_seen++;
          end
        end
        prev_sclk = led_sclk;
      end
    end
  end

  // one write-stream clk: address now, its data presented on the following clk
  task automatic wr_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #2;
    wr_if.wtaddr = a;
    wr_if.wtdina = pend_d;
    pend_d       = d;
  endtask

  task automatic pulse_sdbp();
    @(posedge clk); #2;
    wr_if.sdbpflag = 1'b1;
    wr_if.wtaddr   = '0;
    wr_if.wtdina   = pend_d;
    pend_d         = '0;
    wr_cycle('0, '0);
    @(posedge clk); #2;
    wr_if.sdbpflag = 1'b0;
    wr_if.wtaddr   = '0;
    wr_if.wtdina   = pend_d;
    pend_d         = '0;
  endtask

  // accepted trigger: the bank written so far becomes the transmitted frame
  task automatic trigger(input string tag);
    for (int i = 0; i < NUM_LED; i++) exp_q.push_back(model[wr_sel][i]);
    wr_sel      = 1 - wr_sel;
    busy_cycles = 0;
    lat_cycles  = 0;
    drop_cycles = 0;
    words_seen  = 0;
    $display("trigger %s: expecting %0d words", tag, NUM_LED);
    pulse_sdbp();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (busy && n < FRAME_CLK + 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_done_in_time"}, busy, 0);
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic frame_checks(input string tag, input int exp_cnt, input int exp_drop);
    chk({tag, "_busy_cycles"}, busy_cycles, FRAME_CLK);
    chk({tag, "_lat_cycles"}, lat_cycles, LATCH_LEN);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
    chk({tag, "_words_seen"}, words_seen, NUM_LED);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_drop_cycles"}, drop_cycles, exp_drop);
    $display("frame %s: busy=%0d lat=%0d cnt=%0d words=%0d drops=%0d",
             tag, busy_cycles, lat_cycles, frame_cnt, words_seen, drop_cycles);
  endtask

  initial begin
    int r0, n;

    filt_tbl[0] = '{10'd0,    16'hAAAA, -1};   // idle address
    filt_tbl[1] = '{10'd361,  16'hAAAA, -1};   // beyond last LED
    filt_tbl[2] = '{10'd5,    16'h1234,  4};   // LED 4 written
    filt_tbl[3] = '{10'd5,    16'hAAAA, -1};   // repeated address
    filt_tbl[4] = '{10'd1023, 16'hAAAA, -1};   // far out of range
    filt_tbl[5] = '{10'd360,  16'h5A5A, 359};  // last valid address
    filt_tbl[6] = '{10'd1,    16'h0F0F,  0};   // first valid address

    wr_if.sdbpflag = 1'b0;
    wr_if.wtaddr   = '0;
    wr_if.wtdina   = '0;

    // reset held with random inputs: every output stays 0
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      wr_if.sdbpflag = 1'($urandom);
      wr_if.wtaddr   = AW'($urandom);
      wr_if.wtdina   = DW'($urandom);
      chk($sformatf("reset_outputs[%0d]", i),
          {led_sclk, led_sdo, led_lat, busy, frame_drop, frame_cnt}, 0);
    end
    @(posedge clk); #2;
    wr_if.sdbpflag = 1'b0;
    wr_if.wtaddr   = '0;
    wr_if.wtdina   = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // no trigger for 1000 clk: SCLK stays quiet
    r0 = sclk_rises;
    busy_cycles = 0;
    repeat (1000) @(posedge clk);
    #2;
    chk("idle_sclk_rises", sclk_rises - r0, 0);
    chk("idle_busy_cycles", busy_cycles, 0);
    chk("idle_frame_cnt", frame_cnt, 0);

    // frame A: ramp into bank 0, then all-ones into bank 1 while it is sent
    for (int i = 1; i <= NUM_LED; i++) begin
      wr_cycle(AW'(i), DW'(i - 1));
      model[0][i - 1] = DW'(i - 1);
    end
    wr_cycle('0, '0);
    trigger("A");
    for (int i = 1; i <= NUM_LED; i++) begin
      wr_cycle(AW'(i), 16'hFFFF);
      model[1][i - 1] = 16'hFFFF;
    end
    wr_cycle('0, '0);
    wait_done("A");
    frame_checks("A", 1, 0);

    // frame B: all-ones; filtered writes land in bank 0, plus a dropped trigger
    trigger("B");
    for (int i = 0; i < 7; i++) begin
      wr_cycle(filt_tbl[i].addr, filt_tbl[i].data);
      if (filt_tbl[i].led >= 0) model[0][filt_tbl[i].led] = filt_tbl[i].data;
      $display("filter write addr=%0d data=0x%04h led=%0d",
               filt_tbl[i].addr, filt_tbl[i].data, filt_tbl[i].led);
    end
    wr_cycle('0, '0);
    repeat (200) @(posedge clk);
    #2;
    pulse_sdbp();
    repeat (4) @(posedge clk);
    #2;
    chk("B_drop_pulse", drop_cycles, 1);
    wait_done("B");
    frame_checks("B", 2, 1);

    // frame C: reset asserted once word 100 has been decoded
    trigger("C");
    n = 0;
    while (words_seen < 100 && n < 5000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("C_reached_word_100", (words_seen >= 100), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs_now",
        {led_sclk, led_sdo, led_lat, busy, frame_drop, frame_cnt}, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("midreset_outputs_held",
        {led_sclk, led_sdo, led_lat, busy, frame_drop, frame_cnt}, 0);
    exp_q.delete();
    rst_n  = 1'b1;
    wr_sel = 0;
    repeat (5) @(posedge clk);
    #2;
    chk("postreset_busy", busy, 0);
    chk("postreset_frame_cnt", frame_cnt, 0);

    // frame D: bank 0 still holds the ramp with the filtered edits
    trigger("D");
    wait_done("D");
    frame_checks("D", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(90000 * 40);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
